// File: rtl/fdiv_seq.sv
// fdiv_seq: issue/retire sequencer in front of the fixed-latency fdiv divider
module fdiv_seq #(
  parameter int LAT  = 16,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_x,
  input  logic [31:0]     in_y,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_rslt,
  output logic [4:0]      out_flag,
  output logic [TAGW-1:0] out_tag,
  output logic            div_req,
  output logic [31:0]     div_x,
  output logic [31:0]     div_y,
  input  logic [31:0]     div_rslt,
  input  logic [4:0]      div_flag,
  output logic [4:0]      fflags,
  input  logic            fflags_clr,
  output logic            busy
);
  localparam int CW = (LAT > 2) ? $clog2(LAT) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state;
  logic [CW-1:0] wcnt;
  logic [TAGW-1:0] op_tag;
  logic accept;
  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept = in_valid && in_ready;
  assign busy = state != IDLE;
  // sequencer: latch operands, pulse req once, count out the divider latency, hold result until taken
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      div_req   <= 1'b0;
      div_x     <= '0;
      div_y     <= '0;
      op_tag    <= '0;
      out_valid <= 1'b0;
      out_rslt  <= '0;
      out_flag  <= '0;
      out_tag   <= '0;
      fflags    <= '0;
      wcnt      <= '0;
    end else begin
      if (fflags_clr) fflags <= '0;
      if (accept) begin
        div_x   <= in_x;
        div_y   <= in_y;
        op_tag  <= in_tag;
        div_req <= 1'b1;
        state   <= ISSUE;
      end
      case (state)
        ISSUE: begin
          div_req <= 1'b0;
          wcnt    <= CW'(LAT - 1);
          state   <= WAIT;
        end
        WAIT: begin
          if (wcnt != '0) wcnt <= wcnt - CW'(1);
          else begin
            out_rslt  <= div_rslt;
            out_flag  <= div_flag;
            out_tag   <= op_tag;
            out_valid <= 1'b1;
            fflags    <= (fflags_clr ? 5'b0 : fflags) | div_flag;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!in_valid) state <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fdiv_seq.sv
// tb_fdiv_seq: directed checks of fdiv_seq against a latency-exact fdiv stand-in
module tb_fdiv_seq;
  localparam int LAT = 16;
  localparam int TAGW = 4;
  logic clk = 0, reset = 1;
  logic in_valid = 0, in_ready;
  logic [31:0] in_x = 0, in_y = 0;
  logic [TAGW-1:0] in_tag = 0;
  logic out_valid, out_ready = 0;
  logic [31:0] out_rslt;
  logic [4:0] out_flag;
  logic [TAGW-1:0] out_tag;
  logic div_req;
  logic [31:0] div_x, div_y, div_rslt;
  logic [4:0] div_flag, fflags;
  logic fflags_clr = 0, busy;
  int checks = 0, errors = 0;
  int req_cnt = 0, overlap = 0, stab_err = 0;
  int mcnt = 0;
  logic [31:0] mx = 0, my = 0;
  fdiv_seq #(.LAT(LAT), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_rslt(out_rslt), .out_flag(out_flag),
    .out_tag(out_tag), .div_req(div_req), .div_x(div_x), .div_y(div_y),
    .div_rslt(div_rslt), .div_flag(div_flag), .fflags(fflags),
    .fflags_clr(fflags_clr), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [36:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    if (x == 32'h3F800000 && y == 32'h40000000) return {32'h3F000000, 5'b00000};
    if (x == 32'h3F800000 && y == 32'h40400000) return {32'h3EAAAAAB, 5'b00001};
    if (x == 32'h3F800000 && y == 32'h00000000) return {32'h7F800000, 5'b01000};
    if (x == 32'h00000000 && y == 32'h00000000) return {32'hFFC00000, 5'b10000};
    return {32'h12345678, 5'b00110};
  endfunction
  logic [36:0] ref_now;
  assign ref_now = ref_div(div_x, div_y);
  assign div_rslt = (mcnt == LAT) ? ref_now[36:5] : 32'hDEADBEEF;
  assign div_flag = (mcnt == LAT) ? ref_now[4:0] : 5'b11111;
  always @(posedge clk) begin
    if (div_req) req_cnt++;
    if (reset) mcnt <= 0;
    else if (div_req) begin
      if (mcnt != 0 && mcnt < LAT) overlap++;
      mcnt <= 1;
      mx <= div_x;
      my <= div_y;
    end else if (mcnt != 0 && mcnt < LAT) begin
      mcnt <= mcnt + 1;
      if (div_x != mx || div_y != my) stab_err++;
    end
  end
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic start(input logic [31:0] x, input logic [31:0] y, input logic [TAGW-1:0] t);
    int n = 0;
    in_valid = 1; in_x = x; in_y = y; in_tag = t;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 40) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!out_valid && n < 40);
    if (n >= 40) chk("result_timeout", 0, 1);
  endtask
  task automatic pop();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask
  initial begin
    int n, bp_bad, r0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_div_req", div_req, 0);
    chk("rst_div_x", div_x, 0);
    chk("rst_fflags", fflags, 0);
    reset = 0;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
    r0 = req_cnt;
    start(32'h3F800000, 32'h40000000, 4'd1);
    wait_out(n);
    chk("lat_1_2", n, 17);
    chk("rslt_1_2", out_rslt, 32'h3F000000);
    chk("flag_1_2", out_flag, 5'b00000);
    chk("tag_1_2", out_tag, 1);
    chk("req_pulses", req_cnt - r0, 1);
    pop();
    chk("out_valid_drop", out_valid, 0);
    chk("back_idle", busy, 0);
    start(32'h3F800000, 32'h40400000, 4'd2);
    wait_out(n);
    chk("rslt_1_3", out_rslt, 32'h3EAAAAAB);
    chk("flag_1_3", out_flag, 5'b00001);
    chk("operand_stable", stab_err, 0);
    pop();
    fflags_clr = 1; @(posedge clk); #1; fflags_clr = 0;
    chk("fflags_cleared", fflags, 0);
    start(32'h3F800000, 32'h00000000, 4'd3);
    wait_out(n);
    chk("rslt_dz", out_rslt, 32'h7F800000);
    chk("flag_dz", out_flag, 5'b01000);
    pop();
    start(32'h00000000, 32'h00000000, 4'd4);
    wait_out(n);
    chk("rslt_nv", out_rslt, 32'hFFC00000);
    chk("flag_nv", out_flag, 5'b10000);
    chk("fflags_sticky", fflags, 5'b11000);
    pop();
    fflags_clr = 1; @(posedge clk); #1; fflags_clr = 0;
    chk("fflags_clr_pulse", fflags, 0);
    start(32'h3F800000, 32'h00000000, 4'd6);
    wait_out(n);
    pop();
    chk("fflags_dz_only", fflags, 5'b01000);
    start(32'h3F800000, 32'h40400000, 4'd7);
    repeat (16) @(posedge clk);
    #1;
    chk("pre_capture_valid", out_valid, 0);
    fflags_clr = 1; @(posedge clk); #1; fflags_clr = 0;
    chk("capture_valid", out_valid, 1);
    chk("fflags_clr_at_capture", fflags, 5'b00001);
    pop();
    start(32'h3F800000, 32'h40000000, 4'd3);
    wait_out(n);
    in_valid = 1; in_x = 32'h3F800000; in_y = 32'h40400000; in_tag = 4'd5;
    bp_bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (in_ready || !out_valid || out_tag != 3 || out_rslt != 32'h3F000000 || div_x != 32'h3F800000 || div_y != 32'h40000000) bp_bad++;
    end
    chk("backpressure_hold", bp_bad, 0);
    out_ready = 1;
    #1;
    chk("in_ready_on_pop", in_ready, 1);
    chk("first_tag", out_tag, 3);
    @(posedge clk); #1;
    out_ready = 0; in_valid = 0;
    chk("bp_valid_drop", out_valid, 0);
    chk("bp_issue_next", div_req, 1);
    chk("bp_div_y", div_y, 32'h40400000);
    wait_out(n);
    chk("bp_lat", n, 17);
    chk("bp_tag", out_tag, 5);
    chk("bp_rslt", out_rslt, 32'h3EAAAAAB);
    pop();
    start(32'h3F800000, 32'h40000000, 4'd2);
    repeat (9) @(posedge clk);
    #1;
    chk("pre_reset_busy", busy, 1);
    reset = 1; @(posedge clk); #1; reset = 0;
    chk("abort_busy", busy, 0);
    chk("abort_div_req", div_req, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_fflags", fflags, 0);
    chk("abort_in_ready", in_ready, 1);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_result", out_valid, 0);
    start(32'h3F800000, 32'h40000000, 4'd9);
    wait_out(n);
    chk("post_reset_lat", n, 17);
    chk("post_reset_rslt", out_rslt, 32'h3F000000);
    chk("post_reset_tag", out_tag, 9);
    pop();
    chk("no_overlap", overlap, 0);
    chk("operand_stable_all", stab_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
